// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray-code output, terminal-count
// flag, one-cycle wrap pulse and an independent registered Gray-to-binary
// decoder. WRAP selects modulo wrap-around or saturation at the limits.
module gray_counter #(
  parameter int WIDTH = 4,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             wrap,
  output logic [WIDTH-1:0] dec_out
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] dec_q, dec_d;
  logic             wrap_q, wrap_d;
  logic             at_top, at_bottom;

  assign at_top    = (bin_q == MAX_VAL);
  assign at_bottom = (bin_q == ZERO_VAL);

  // Terminal count looks only at the current count and direction, not en.
  assign tc = up ? at_top : at_bottom;

  // Next count: load wins over en; at a limit either wrap (with pulse) or hold.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          if (WRAP != 0) begin
            bin_d  = ZERO_VAL;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q + ONE_VAL;
        end
      end else begin
        if (at_bottom) begin
          if (WRAP != 0) begin
            bin_d  = MAX_VAL;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q - ONE_VAL;
        end
      end
    end
    // Gray is encoded from the next count so it is registered alongside it.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // Decoder: each binary bit is the XOR of all Gray bits at or above it.
  // Written as a reduction per bit to avoid a bit-to-bit feedback chain.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
    assign dec_d[gi] = ^gray_in[WIDTH-1:gi];
  end

  // State registers; reset clears everything immediately, including a pending wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= ZERO_VAL;
      gray_q <= ZERO_VAL;
      wrap_q <= 1'b0;
      dec_q  <= ZERO_VAL;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      dec_q  <= dec_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;
  assign dec_out  = dec_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: one wrapping (WRAP=1) and one
// saturating (WRAP=0) instance share stimulus and are compared against a
// behavioural model based on modular arithmetic and a Gray lookup search.
module tb_gray_counter;
  localparam int W    = 4;
  localparam int MAXV = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0, up = 1'b1, load = 1'b0;
  logic [W-1:0] load_bin = '0, gray_in = '0;
  logic [W-1:0] bin1, gray1, dec1, bin0, gray0, dec0;
  logic         tc1, wrap1, tc0, wrap0;

  int errors = 0;
  int checks = 0;

  // model state
  int m1 = 0, m0 = 0, mdec = 0;
  bit w1 = 0, w0 = 0, step1 = 0, step0 = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_bin(load_bin), .gray_in(gray_in), .bin_out(bin1),
    .gray_out(gray1), .tc(tc1), .wrap(wrap1), .dec_out(dec1));

  gray_counter #(.WIDTH(W), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_bin(load_bin), .gray_in(gray_in), .bin_out(bin0),
    .gray_out(gray0), .tc(tc0), .wrap(wrap0), .dec_out(dec0));

  function automatic int gray_of(int b);
    return b ^ (b >> 1);
  endfunction

  // Decode by searching for the binary value whose Gray code matches.
  function automatic int decode(int g);
    for (int b = 0; b <= MAXV; b++) if (gray_of(b) == g) return b;
    return -1;
  endfunction

  function automatic bit tc_of(int m, bit dir_up);
    return dir_up ? (m == MAXV) : (m == 0);
  endfunction

  task automatic model_step(inout int m, inout bit w, output bit stepped, input bit wrapmode);
    int nxt;
    stepped = 0;
    w = 0;
    if (load) begin
      m = load_bin;
    end else if (en) begin
      nxt = up ? m + 1 : m - 1;
      if (nxt >= 0 && nxt <= MAXV) begin
        m = nxt;
        stepped = 1;
      end else if (wrapmode) begin
        m = (nxt + MAXV + 1) % (MAXV + 1);
        w = 1;
        stepped = 1;
      end
    end
  endtask

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic tick();
    if (rst_n) begin
      model_step(m1, w1, step1, 1'b1);
      model_step(m0, w0, step0, 1'b0);
      mdec = decode(int'(gray_in));
    end else begin
      step1 = 0;
      step0 = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1; up = 1'b1; gray_in = 4'hC;
    #2;
    checks++; if (bin1 !== 4'd0) begin errors++; $display("FAIL reset_bin: got %0h expected 0", bin1); end
    checks++; if (gray1 !== 4'd0) begin errors++; $display("FAIL reset_gray: got %0h expected 0", gray1); end
    checks++; if (wrap1 !== 1'b0 || wrap0 !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0b/%0b expected 0", wrap1, wrap0); end
    checks++; if (dec1 !== 4'd0) begin errors++; $display("FAIL reset_dec: got %0h expected 0", dec1); end
    tick(); tick();
    checks++; if (bin1 !== 4'd0 || bin0 !== 4'd0 || dec1 !== 4'd0) begin errors++; $display("FAIL reset_hold: got bin %0h/%0h dec %0h expected 0", bin1, bin0, dec1); end
    en = 1'b0; gray_in = 4'h0;
    rst_n = 1'b1;
    tick();
    checks++; if (bin1 !== 4'd0 || gray1 !== 4'd0) begin errors++; $display("FAIL reset_release: got bin %0h gray %0h expected 0", bin1, gray1); end
  endtask

  task automatic test_count_sequence();
    logic [W-1:0] exp_gray [0:16];
    exp_gray = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    checks++; if (gray1 !== exp_gray[0]) begin errors++; $display("FAIL seq_start: got %0h expected %0h", gray1, exp_gray[0]); end
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      gray_in = gray1;  // round-trip the current Gray code through the decoder
      tick();
      checks++; if (gray1 !== exp_gray[i]) begin errors++; $display("FAIL seq_gray[%0d]: got %0h expected %0h", i, gray1, exp_gray[i]); end
      checks++; if (wrap1 !== (i == 16)) begin errors++; $display("FAIL seq_wrap[%0d]: got %0b expected %0b", i, wrap1, (i == 16)); end
      checks++; if (tc1 !== (i == 15)) begin errors++; $display("FAIL seq_tc[%0d]: got %0b expected %0b", i, tc1, (i == 15)); end
      checks++; if (dec1 !== 4'(i - 1)) begin errors++; $display("FAIL seq_roundtrip[%0d]: got %0h expected %0h", i, dec1, 4'(i - 1)); end
    end
    en = 1'b0;
    tick();
    checks++; if (wrap1 !== 1'b0 || bin1 !== 4'd0) begin errors++; $display("FAIL seq_wrap_end: got wrap %0b bin %0h expected 0/0", wrap1, bin1); end
  endtask

  task automatic test_load();
    load = 1'b1; load_bin = 4'd10; en = 1'b1; up = 1'b1;
    tick();
    checks++; if (bin1 !== 4'd10 || gray1 !== 4'hF || wrap1 !== 1'b0) begin errors++; $display("FAIL load: got bin %0h gray %0h wrap %0b expected a/f/0", bin1, gray1, wrap1); end
    load = 1'b0; up = 1'b0;
    tick();
    checks++; if (bin1 !== 4'd9 || gray1 !== 4'hD) begin errors++; $display("FAIL load_down: got bin %0h gray %0h expected 9/d", bin1, gray1); end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    load = 1'b1; load_bin = 4'd0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    checks++; if (bin1 !== 4'd15 || gray1 !== 4'h8 || wrap1 !== 1'b1) begin errors++; $display("FAIL down_wrap: got bin %0h gray %0h wrap %0b expected f/8/1", bin1, gray1, wrap1); end
    checks++; if (bin0 !== 4'd0 || wrap0 !== 1'b0) begin errors++; $display("FAIL sat_low: got bin %0h wrap %0b expected 0/0", bin0, wrap0); end
    en = 1'b0;
    tick();
    checks++; if (wrap1 !== 1'b0 || bin1 !== 4'd15) begin errors++; $display("FAIL down_wrap_pulse: got wrap %0b bin %0h expected 0/f", wrap1, bin1); end
  endtask

  task automatic test_saturate();
    load = 1'b1; load_bin = 4'd15;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bin0 !== 4'd15 || gray0 !== 4'h8 || wrap0 !== 1'b0 || tc0 !== 1'b1) begin
        errors++; $display("FAIL sat_high[%0d]: got bin %0h gray %0h wrap %0b tc %0b expected f/8/0/1", i, bin0, gray0, wrap0, tc0);
      end
    end
    en = 1'b0; up = 1'b0;
    #1;
    checks++; if (tc0 !== 1'b0) begin errors++; $display("FAIL sat_tc_dir: got %0b expected 0", tc0); end
    tick();
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_bin = 4'd0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1; gray_in = 4'hC;
    repeat (6) tick();
    checks++; if (bin1 !== 4'd6 || dec1 !== 4'd8) begin errors++; $display("FAIL areset_pre: got bin %0h dec %0h expected 6/8", bin1, dec1); end
    #3;
    rst_n = 1'b0; load = 1'b1; load_bin = 4'd9;
    m1 = 0; m0 = 0; w1 = 0; w0 = 0; mdec = 0;
    #1;
    checks++; if (bin1 !== 4'd0 || gray1 !== 4'd0 || dec1 !== 4'd0 || wrap1 !== 1'b0) begin
      errors++; $display("FAIL areset_mid: got bin %0h gray %0h dec %0h wrap %0b expected 0", bin1, gray1, dec1, wrap1);
    end
    tick();
    checks++; if (bin1 !== 4'd0 || bin0 !== 4'd0) begin errors++; $display("FAIL areset_dominates: got %0h/%0h expected 0", bin1, bin0); end
    load = 1'b0; rst_n = 1'b1;
    tick();
    checks++; if (bin1 !== 4'd1 || gray1 !== 4'd1) begin errors++; $display("FAIL areset_resume: got bin %0h gray %0h expected 1/1", bin1, gray1); end
    en = 1'b0;
  endtask

  task automatic test_decode();
    gray_in = 4'hC;
    tick();
    checks++; if (dec1 !== 4'h8) begin errors++; $display("FAIL decode_c: got %0h expected 8", dec1); end
    gray_in = 4'h8;
    tick();
    checks++; if (dec1 !== 4'hF) begin errors++; $display("FAIL decode_8: got %0h expected f", dec1); end
  endtask

  task automatic test_random();
    logic [W-1:0] prev1, prev0;
    for (int n = 0; n < 400; n++) begin
      en       = ($urandom_range(0, 3) != 0);
      up       = $urandom_range(0, 1);
      load     = ($urandom_range(0, 15) == 0);
      load_bin = W'($urandom);
      gray_in  = W'($urandom);
      prev1 = gray1;
      prev0 = gray0;
      tick();
      checks++; if (bin1 !== 4'(m1) || gray1 !== 4'(gray_of(m1)) || wrap1 !== w1 || tc1 !== tc_of(m1, up)) begin
        errors++; $display("FAIL rand_wrap[%0d]: got bin %0h gray %0h wrap %0b tc %0b expected %0h/%0h/%0b/%0b", n, bin1, gray1, wrap1, tc1, m1, gray_of(m1), w1, tc_of(m1, up));
      end
      checks++; if (bin0 !== 4'(m0) || gray0 !== 4'(gray_of(m0)) || wrap0 !== w0 || tc0 !== tc_of(m0, up)) begin
        errors++; $display("FAIL rand_sat[%0d]: got bin %0h gray %0h wrap %0b tc %0b expected %0h/%0h/%0b/%0b", n, bin0, gray0, wrap0, tc0, m0, gray_of(m0), w0, tc_of(m0, up));
      end
      checks++; if (dec1 !== 4'(mdec) || dec0 !== 4'(mdec)) begin
        errors++; $display("FAIL rand_dec[%0d]: got %0h/%0h expected %0h", n, dec1, dec0, mdec);
      end
      if (step1 && !load) begin
        checks++; if ($countones(gray1 ^ prev1) != 1) begin errors++; $display("FAIL rand_onebit_wrap[%0d]: got %0h after %0h expected one-bit change", n, gray1, prev1); end
      end
      if (step0 && !load) begin
        checks++; if ($countones(gray0 ^ prev0) != 1) begin errors++; $display("FAIL rand_onebit_sat[%0d]: got %0h after %0h expected one-bit change", n, gray0, prev0); end
      end
    end
    en = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_sequence();
    test_load();
    test_down_wrap();
    test_saturate();
    test_async_reset();
    test_decode();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter and converter width in bits (legal range 2..32).
REQ-002 SHALL have parameter WRAP, default 1: 1 = modulo-2^WIDTH wrap; 0 = saturate at the limits.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port en  input  1: count enable.
REQ-006 SHALL have port up  input  1: direction, 1 = increment, 0 = decrement.
REQ-007 SHALL have port load  input  1: synchronous load strobe.
REQ-008 SHALL have port load_bin  input  WIDTH: binary value to load.
REQ-009 SHALL have port gray_in  input  WIDTH: Gray word to decode.
REQ-010 SHALL have port bin_out  output  WIDTH: registered binary count.
REQ-011 SHALL have port gray_out  output  WIDTH: registered Gray encoding of the count.
REQ-012 SHALL have port tc  output  1: terminal count, combinational.
REQ-013 SHALL have port wrap  output  1: registered one-cycle wrap pulse.
REQ-014 SHALL have port dec_out  output  WIDTH: registered binary decode of gray_in.

Function
REQ-015 SHALL hold the count in an internal binary register; bin_out SHALL be that register.
REQ-016 SHALL compute gray_out on the same edge as bin_out from the next binary value (next ^ (next >> 1)), so gray_out always equals bin_out ^ (bin_out >> 1), with no combinational path from inputs to gray_out.
REQ-017 SHALL apply priority load > en: load=1 sets count to load_bin regardless of en or up, and wrap is 0 that cycle.
REQ-018 SHALL, with load=0 and en=1, up=1, increment by 1; with up=0, decrement by 1.
REQ-019 SHALL hold the count when load=0 and en=0.
REQ-020 SHALL, with WRAP=1, wrap up at 2^WIDTH-1 to 0 and down at 0 to 2^WIDTH-1, asserting wrap for exactly the cycle after that edge.
REQ-021 SHALL, with WRAP=0, hold the count at 2^WIDTH-1 (up) or 0 (down) when an enabled step would cross the limit, and SHALL never assert wrap.
REQ-022 SHALL drive tc = 1 when (up=1 and bin_out=2^WIDTH-1) or (up=0 and bin_out=0), independent of en.
REQ-023 SHALL guarantee that successive gray_out values differ in exactly one bit for every enabled non-saturating count step, including wrap.
REQ-024 SHALL register dec_out each cycle with latency 1: dec_out[WIDTH-1] = gray_in[WIDTH-1], dec_out[i] = dec_out[i+1] ^ gray_in[i], unconditionally (not gated by en).
REQ-025 SHALL carry all arithmetic modulo 2^WIDTH, with no carry-out port.

Reset
REQ-026 SHALL, on rst_n low, immediately and asynchronously force bin_out=0, gray_out=0, wrap=0, and dec_out=0, regardless of clk.
REQ-027 SHALL hold all registers at reset values while rst_n=0; the first count or load takes effect on the first rising clk edge with rst_n=1.
REQ-028 SHALL make reset asserted mid-count dominate load and en; no pending wrap pulse survives reset.

Verification (WIDTH=4)
REQ-029 Reset, then en=1 up=1 for 16 edges -> gray_out 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8 then 0; wrap=1 only in the cycle after 8->0; tc=1 while bin_out=15.
REQ-030 load=1 load_bin=10 together with en=1 -> next cycle bin_out=10, gray_out=F, wrap=0; a following en=1 up=0 edge -> bin_out=9, gray_out=D.
REQ-031 WRAP=1, bin_out=0, en=1 up=0 -> bin_out=15, gray_out=8, wrap pulse for one cycle.
REQ-032 WRAP=0, bin_out=15, en=1 up=1 for 3 edges -> bin_out stays 15, gray_out stays 8, wrap=0, tc=1; switching to up=0 makes tc=0.
REQ-033 Counting at bin_out=6, drop rst_n between edges -> bin_out, gray_out, and dec_out read 0 before the next edge; release rst_n -> count resumes from 0.
REQ-034 Drive gray_in=C, then gray_in=8 -> dec_out=8 one edge later, then dec_out=F one edge later; all 16 codes round-trip against gray_out.
